// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Purpose  : MIPS MEM pipeline stage. The EX-stage ALU result is used as a
//             byte address into an internal word-organised data memory.
//             Aligned LB/LBU/LH/LHU/LW and SB/SH/SW are supported. Load data,
//             pass-through results and WB controls are registered into the
//             MEM/WB latch. A registered debug port lets the debug unit dump
//             memory independently of the pipeline enable.
//  Ports    : i_clk, i_reset (sync, active-high), i_enable (pipeline step)
//             i_alu_result, i_write_data, i_mem_read, i_mem_write, i_width,
//             i_unsigned, i_reg_write, i_mem_to_reg, i_rd_addr  (from EX)
//             o_read_data, o_alu_result, o_rd_addr, o_reg_write,
//             o_mem_to_reg, o_misaligned                         (MEM/WB)
//             i_dbg_addr -> o_dbg_data                           (debug)
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int REG_SIZE  = 32,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [REG_SIZE-1:0]  i_alu_result,
    input  logic [REG_SIZE-1:0]  i_write_data,
    input  logic                 i_mem_read,
    input  logic                 i_mem_write,
    input  logic [1:0]           i_width,
    input  logic                 i_unsigned,
    input  logic                 i_reg_write,
    input  logic                 i_mem_to_reg,
    input  logic [4:0]           i_rd_addr,
    input  logic [ADDR_BITS-1:0] i_dbg_addr,
    output logic [REG_SIZE-1:0]  o_read_data,
    output logic [REG_SIZE-1:0]  o_alu_result,
    output logic [4:0]           o_rd_addr,
    output logic                 o_reg_write,
    output logic                 o_mem_to_reg,
    output logic                 o_misaligned,
    output logic [REG_SIZE-1:0]  o_dbg_data
);

    // Byte lanes per word; the two low address bits select the lane, so the
    // datapath is assumed to be 32 bits wide.
    localparam int         c_LANES      = 4;
    localparam logic [1:0] c_WIDTH_BYTE = 2'b00;
    localparam logic [1:0] c_WIDTH_HALF = 2'b01;

    logic [REG_SIZE-1:0]  r_mem [MEM_DEPTH];

    logic [REG_SIZE-1:0]  r_read_data;
    logic [REG_SIZE-1:0]  r_alu_result;
    logic [4:0]           r_rd_addr;
    logic                 r_reg_write;
    logic                 r_mem_to_reg;
    logic                 r_misaligned;
    logic [REG_SIZE-1:0]  r_dbg_data;

    logic [ADDR_BITS-1:0] w_word_idx;
    logic [1:0]           w_lane;
    logic                 w_misaligned;
    logic                 w_do_store;
    logic [REG_SIZE-1:0]  w_old_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [REG_SIZE-1:0]  w_load_data;
    logic [c_LANES-1:0]   w_byte_en;
    logic [REG_SIZE-1:0]  w_store_data;

    // Upper address bits beyond the memory size are ignored, giving wrap.
    assign w_word_idx = i_alu_result[ADDR_BITS+1:2];
    assign w_lane     = i_alu_result[1:0];

    // Width 2'b10 is handled as a word access.
    always_comb begin
        w_misaligned = 1'b0;
        if (i_mem_read || i_mem_write) begin
            if (i_width == c_WIDTH_HALF)
                w_misaligned = w_lane[0];
            else if (i_width != c_WIDTH_BYTE)
                w_misaligned = (w_lane != 2'b00);
        end
    end

    assign w_do_store = i_enable && i_mem_write && !w_misaligned;

    // Combinational read of the current contents: a store on this same edge
    // has not landed yet, so a combined read/write returns the old word.
    assign w_old_word = r_mem[w_word_idx];

    always_comb begin
        w_byte = w_old_word[7:0];
        case (w_lane)
            2'd0:    w_byte = w_old_word[7:0];
            2'd1:    w_byte = w_old_word[15:8];
            2'd2:    w_byte = w_old_word[23:16];
            default: w_byte = w_old_word[31:24];
        endcase
        w_half = w_lane[1] ? w_old_word[31:16] : w_old_word[15:0];
    end

    always_comb begin
        w_load_data = '0;
        if (i_mem_read && !w_misaligned) begin
            case (i_width)
                c_WIDTH_BYTE:
                    w_load_data = {{(REG_SIZE-8){w_byte[7] & ~i_unsigned}}, w_byte};
                c_WIDTH_HALF:
                    w_load_data = {{(REG_SIZE-16){w_half[15] & ~i_unsigned}}, w_half};
                default:
                    w_load_data = w_old_word;
            endcase
        end
    end

    // Store data is replicated across lanes so each enabled lane simply takes
    // its own slice.
    always_comb begin
        w_byte_en    = '0;
        w_store_data = i_write_data;
        case (i_width)
            c_WIDTH_BYTE: begin
                w_store_data = {c_LANES{i_write_data[7:0]}};
                case (w_lane)
                    2'd0:    w_byte_en = 4'b0001;
                    2'd1:    w_byte_en = 4'b0010;
                    2'd2:    w_byte_en = 4'b0100;
                    default: w_byte_en = 4'b1000;
                endcase
            end
            c_WIDTH_HALF: begin
                w_store_data = {2{i_write_data[15:0]}};
                w_byte_en    = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_store_data = i_write_data;
                w_byte_en    = 4'b1111;
            end
        endcase
    end

    // Data memory; reset clears every word and discards a concurrent store.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < MEM_DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_do_store) begin
            for (int k = 0; k < c_LANES; k++)
                if (w_byte_en[k])
                    r_mem[w_word_idx][8*k +: 8] <= w_store_data[8*k +: 8];
        end
    end

    // MEM/WB latch
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (i_enable) begin
            r_read_data  <= w_load_data;
            r_alu_result <= i_alu_result;
            r_rd_addr    <= i_rd_addr;
            r_reg_write  <= i_reg_write && !(w_misaligned && i_mem_read);
            r_mem_to_reg <= i_mem_to_reg;
            r_misaligned <= w_misaligned;
        end
    end

    // Debug read runs every cycle regardless of the pipeline enable.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_dbg_data <= '0;
        else
            r_dbg_data <= r_mem[i_dbg_addr];
    end

    assign o_read_data  = r_read_data;
    assign o_alu_result = r_alu_result;
    assign o_rd_addr    = r_rd_addr;
    assign o_reg_write  = r_reg_write;
    assign o_mem_to_reg = r_mem_to_reg;
    assign o_misaligned = r_misaligned;
    assign o_dbg_data   = r_dbg_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Purpose  : Directed scoreboard bench for mem_stage. Each issued cycle
//             pushes its hand-computed MEM/WB expectation into a queue; a
//             monitor pops and compares one cycle after issue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] write_data = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  width = 2'b11;
    logic        unsgn = 1'b0;
    logic        reg_write = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic [4:0]  rd_addr = '0;
    logic [7:0]  dbg_addr = '0;

    logic [31:0] read_data_o;
    logic [31:0] alu_result_o;
    logic [4:0]  rd_addr_o;
    logic        reg_write_o;
    logic        mem_to_reg_o;
    logic        misaligned_o;
    logic [31:0] dbg_data_o;

    always #5 clk = ~clk;

    mem_stage #(.REG_SIZE(32), .MEM_DEPTH(256), .ADDR_BITS(8)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_enable     (enable),
        .i_alu_result (alu_result),
        .i_write_data (write_data),
        .i_mem_read   (mem_read),
        .i_mem_write  (mem_write),
        .i_width      (width),
        .i_unsigned   (unsgn),
        .i_reg_write  (reg_write),
        .i_mem_to_reg (mem_to_reg),
        .i_rd_addr    (rd_addr),
        .i_dbg_addr   (dbg_addr),
        .o_read_data  (read_data_o),
        .o_alu_result (alu_result_o),
        .o_rd_addr    (rd_addr_o),
        .o_reg_write  (reg_write_o),
        .o_mem_to_reg (mem_to_reg_o),
        .o_misaligned (misaligned_o),
        .o_dbg_data   (dbg_data_o)
    );

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        mis;
        logic        chk_dbg;
        logic [31:0] dbg;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    logic chk_valid = 1'b0;
    int   n_checks  = 0;
    int   n_pass    = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
    endtask

    // Monitor: every issued cycle yields one MEM/WB result after the edge.
    always @(posedge clk) begin
        if (chk_valid) begin
            #1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL scoreboard_underflow: got output, expected none queued");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, ".read_data"},  read_data_o,           e.rdata);
                check({e.name, ".alu_result"}, alu_result_o,          e.alu);
                check({e.name, ".rd_addr"},    {27'd0, rd_addr_o},    {27'd0, e.rd});
                check({e.name, ".reg_write"},  {31'd0, reg_write_o},  {31'd0, e.rw});
                check({e.name, ".mem_to_reg"}, {31'd0, mem_to_reg_o}, {31'd0, e.m2r});
                check({e.name, ".misaligned"}, {31'd0, misaligned_o}, {31'd0, e.mis});
                if (e.chk_dbg)
                    check({e.name, ".dbg_data"}, dbg_data_o, e.dbg);
            end
        end
    end

    // Generic enabled cycle; rdata and misalignment are hand-supplied.
    task automatic op(input string nm, input logic [31:0] a, input logic [31:0] wd,
                      input logic mr, input logic mw, input logic [1:0] w,
                      input logic uns, input logic rw, input logic m2r,
                      input logic [4:0] rd, input logic [31:0] exp_rdata,
                      input logic exp_mis, input logic [7:0] da,
                      input logic cdbg, input logic [31:0] edbg);
        exp_t e;
        @(negedge clk);
        rst = 1'b0; enable = 1'b1;
        alu_result = a; write_data = wd; mem_read = mr; mem_write = mw;
        width = w; unsgn = uns; reg_write = rw; mem_to_reg = m2r;
        rd_addr = rd; dbg_addr = da; chk_valid = 1'b1;
        e.name = nm; e.rdata = exp_rdata; e.alu = a; e.rd = rd;
        e.rw = rw & ~(exp_mis & mr); e.m2r = m2r; e.mis = exp_mis;
        e.chk_dbg = cdbg; e.dbg = edbg;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    task automatic ld(input string nm, input logic [31:0] a, input logic [1:0] w,
                      input logic uns, input logic [31:0] exp_rdata, input logic exp_mis);
        op(nm, a, 32'h0, 1'b1, 1'b0, w, uns, 1'b1, 1'b1, 5'd9, exp_rdata, exp_mis, 8'd0, 1'b0, 32'h0);
    endtask

    task automatic st(input string nm, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] w, input logic exp_mis);
        op(nm, a, wd, 1'b0, 1'b1, w, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, exp_mis, 8'd0, 1'b0, 32'h0);
    endtask

    // Reset cycle with a store presented: everything zero, store dropped.
    task automatic do_reset(input string nm);
        exp_t e;
        @(negedge clk);
        rst = 1'b1; enable = 1'b1;
        alu_result = 32'h10; write_data = 32'hFFFF_FFFF; mem_read = 1'b0;
        mem_write = 1'b1; width = 2'b11; reg_write = 1'b1; mem_to_reg = 1'b1;
        rd_addr = 5'd7; dbg_addr = 8'd4; chk_valid = 1'b1;
        e.name = nm; e.rdata = '0; e.alu = '0; e.rd = '0; e.rw = 1'b0;
        e.m2r = 1'b0; e.mis = 1'b0; e.chk_dbg = 1'b1; e.dbg = '0;
        exp_q.push_back(e);
        last_exp = e;
    endtask

    // Stalled cycle carrying a store: outputs hold their previous values.
    task automatic stall(input string nm);
        exp_t e;
        @(negedge clk);
        rst = 1'b0; enable = 1'b0;
        alu_result = 32'h20; write_data = 32'h7777_7777; mem_read = 1'b0;
        mem_write = 1'b1; width = 2'b11; reg_write = 1'b1; mem_to_reg = 1'b0;
        rd_addr = 5'd12; chk_valid = 1'b1;
        e = last_exp;
        e.name = nm; e.chk_dbg = 1'b0;
        exp_q.push_back(e);
    endtask

    initial begin
        do_reset("reset0");
        do_reset("reset1");

        st("sw_10",   32'h10, 32'hDEAD_BEEF, 2'b11, 1'b0);
        ld("lw_10",   32'h10, 2'b11, 1'b0, 32'hDEAD_BEEF, 1'b0);
        ld("lb_13",   32'h13, 2'b00, 1'b0, 32'hFFFF_FFDE, 1'b0);
        ld("lbu_13",  32'h13, 2'b00, 1'b1, 32'h0000_00DE, 1'b0);
        ld("lh_10",   32'h10, 2'b01, 1'b0, 32'hFFFF_BEEF, 1'b0);
        ld("lhu_12",  32'h12, 2'b01, 1'b1, 32'h0000_DEAD, 1'b0);
        ld("lbu_10",  32'h10, 2'b00, 1'b1, 32'h0000_00EF, 1'b0);

        st("sb_11",   32'h11, 32'hAAAA_AA55, 2'b00, 1'b0);
        ld("lw_sb",   32'h10, 2'b11, 1'b0, 32'hDEAD_55EF, 1'b0);
        // Same-edge debug read of the word being stored shows the old value.
        op("sh_12", 32'h12, 32'hFFFF_1234, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0,
           5'd0, 32'h0, 1'b0, 8'd4, 1'b1, 32'hDEAD_55EF);
        op("lw_sh", 32'h10, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 1'b1,
           5'd9, 32'h1234_55EF, 1'b0, 8'd4, 1'b1, 32'h1234_55EF);

        st("sw_06_mis", 32'h06, 32'h1111_1111, 2'b11, 1'b1);
        ld("lh_03_mis", 32'h03, 2'b01, 1'b0, 32'h0, 1'b1);
        ld("lw_04_chk", 32'h04, 2'b11, 1'b0, 32'h0, 1'b0);
        ld("lw_10_chk", 32'h10, 2'b11, 1'b0, 32'h1234_55EF, 1'b0);

        // Combined read/write returns the pre-store word.
        op("rw_10", 32'h10, 32'hCAFE_F00D, 1'b1, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0,
           5'd0, 32'h1234_55EF, 1'b0, 8'd0, 1'b0, 32'h0);
        ld("lw10_w10", 32'h10, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);

        stall("stall_sw20");
        ld("lw_20",   32'h20, 2'b11, 1'b0, 32'h0, 1'b0);

        do_reset("reset_mid");
        ld("lw_10_rst", 32'h10, 2'b11, 1'b0, 32'h0, 1'b0);

        op("sw_400", 32'h400, 32'hA5A5_A5A5, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0,
           5'd0, 32'h0, 1'b0, 8'd0, 1'b1, 32'h0);
        op("alu_op", 32'h7, 32'h0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0,
           5'd3, 32'h0, 1'b0, 8'd0, 1'b1, 32'hA5A5_A5A5);

        @(negedge clk);
        chk_valid = 1'b0; enable = 1'b0; mem_write = 1'b0; mem_read = 1'b0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
